// File: rtl/alu_regfile_seq.sv
// Register-file front end for the 16-bit ALU. It accepts rd <- rs op rt, runs IDLE -> EXEC -> WB,
// reports the result on a one-cycle strobe, and writes it back to the 8 x 16 register file (r0 reads 0).
module alu_regfile_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rs,
  input  logic [2:0]  cmd_rt,
  input  logic [2:0]  cmd_rd,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_cout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] regs_q [8];
  logic [1:0]  op_q;
  logic [2:0]  rd_q;
  logic [15:0] a_q, b_q, r_q, r_d;
  logic        c_q, c_d;
  logic [15:0] a_rd, b_rd, b_eff;
  logic [16:0] sum;
  logic        accept, wb_we;

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
  // cmd_ready is high only in IDLE, and cmd_valid outside IDLE is ignored without stalling anything.
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign wb_we     = (state_q == WB) && (rd_q != 3'd0);

  assign a_rd     = (cmd_rs   == 3'd0) ? 16'h0000 : regs_q[cmd_rs];
  assign b_rd     = (cmd_rt   == 3'd0) ? 16'h0000 : regs_q[cmd_rt];
  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs_q[dbg_addr];

  assign rsp_valid = (state_q == WB);
  assign rsp_data  = r_q;
  assign rsp_cout  = c_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // op[0] selects the subtract path (~B + 1); logic ops still report that path's carry.
  always_comb begin
    b_eff = op_q[0] ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {16'h0000, op_q[0]};
    c_d   = sum[16];
    case (op_q)
      2'b10:   r_d = a_q & b_q;
      2'b11:   r_d = a_q | b_q;
      default: r_d = sum[15:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      rd_q    <= 3'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      r_q     <= 16'h0000;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        a_q  <= a_rd;
        b_q  <= b_rd;
      end
      if (state_q == EXEC) begin
        r_q <= r_d;
        c_q <= c_d;
      end
    end
  end

  // Writeback takes priority over a same-address load at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (wb_we && (rd_q == 3'(i)))
          regs_q[i] <= r_q;
        else if (ld_en && (ld_addr == 3'(i)))
          regs_q[i] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: directed and random commands checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_regfile_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rs, cmd_rt, cmd_rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_cout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_regs [8];
  logic [16:0] exp_q [$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  alu_regfile_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .dbg_state(dbg_state)
  );

  // reference model: the ALU rules as plain unsigned arithmetic
  function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ai, bi;
    logic [15:0] r;
    logic        c;
    ai = a;
    bi = b;
    case (op)
      2'd0: begin r = 16'((ai + bi) % 65536);         c = (ai + bi) >= 65536; end
      2'd1: begin r = 16'((ai + 65536 - bi) % 65536); c = (ai >= bi);         end
      2'd2: begin r = a & b;                          c = (ai + bi) >= 65536; end
      default: begin r = a | b;                       c = (ai >= bi);         end
    endcase
    return {c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    step();
    ld_en = 1'b0;
    if (addr != 3'd0) m_regs[addr] = data;
    dbg_addr = addr;
    #1 chk("load_dbg", dbg_data, m_regs[addr]);
  endtask

  task automatic dump_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk(tag, dbg_data, m_regs[i]);
    end
    step();
  endtask

  // phase: 0 no load, 1 load at accept edge, 2 load at EXEC->WB edge, 3 load at WB closing edge
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input int phase, input logic [2:0] laddr,
                         input logic [15:0] ldata, input string tag);
    int n;
    logic [16:0] e;
    n = 0;
    while (!cmd_ready && n < 10) begin step(); n++; end
    chk({tag, "_ready_wait"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    if (phase == 1) begin ld_en = 1'b1; ld_addr = laddr; ld_data = ldata; end
    exp_q.push_back(ref_alu(op, m_regs[rs], m_regs[rt]));
    step();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_rs = 3'($urandom); cmd_rt = 3'($urandom); cmd_rd = 3'($urandom);
    ld_en = 1'b0;
    if (phase == 1 && laddr != 3'd0) m_regs[laddr] = ldata;
    if (phase == 2) begin ld_en = 1'b1; ld_addr = laddr; ld_data = ldata; end
    chk({tag, "_exec_ready"}, cmd_ready, 0);
    chk({tag, "_exec_valid"}, rsp_valid, 0);
    step();
    ld_en = 1'b0;
    if (phase == 2 && laddr != 3'd0) m_regs[laddr] = ldata;
    if (phase == 3) begin ld_en = 1'b1; ld_addr = laddr; ld_data = ldata; end
    e = exp_q.pop_front();
    chk({tag, "_wb_valid"}, rsp_valid, 1);
    chk({tag, "_wb_ready"}, cmd_ready, 0);
    chk({tag, "_data"}, rsp_data, e[15:0]);
    chk({tag, "_cout"}, rsp_cout, e[16]);
    step();
    ld_en = 1'b0;
    if (phase == 3 && laddr != 3'd0) m_regs[laddr] = ldata;
    if (rd != 3'd0) m_regs[rd] = e[15:0];
    chk({tag, "_post_valid"}, rsp_valid, 0);
    chk({tag, "_post_ready"}, cmd_ready, 1);
    chk({tag, "_hold_data"}, rsp_data, e[15:0]);
    dbg_addr = rd;
    #1 chk({tag, "_dbg_rd"}, dbg_data, m_regs[rd]);
    if (phase != 0) begin
      dbg_addr = laddr;
      #1 chk({tag, "_dbg_ld"}, dbg_data, m_regs[laddr]);
    end
  endtask

  initial begin
    logic [16:0] e;
    logic [2:0]  hold_rd;
    logic        prev_valid;

    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    reset = 1'b0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000; dbg_addr = 3'd0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_rd = 3'd3;
    #1;

    // reset state, commands ignored while reset is low
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 16'h0000);
      chk("rst_cout", rsp_cout, 0);
    end
    reset = 1'b1; cmd_valid = 1'b0;
    dump_check("rst_regs");

    // directed test plan
    do_load(3'd1, 16'haa55);
    do_load(3'd2, 16'h55aa);
    run_cmd(2'd0, 3'd1, 3'd2, 3'd3, 0, 3'd0, 16'h0, "add");
    chk("add_const", m_regs[3], 16'hffff);
    do_load(3'd4, 16'hffff);
    do_load(3'd5, 16'h0001);
    do_load(3'd6, 16'h7fff);
    run_cmd(2'd1, 3'd4, 3'd5, 3'd7, 0, 3'd0, 16'h0, "sub_a");
    run_cmd(2'd1, 3'd5, 3'd6, 3'd7, 0, 3'd0, 16'h0, "sub_b");
    run_cmd(2'd2, 3'd1, 3'd2, 3'd3, 0, 3'd0, 16'h0, "and");
    run_cmd(2'd3, 3'd4, 3'd5, 3'd3, 0, 3'd0, 16'h0, "or");
    for (int op = 0; op < 4; op++)
      run_cmd(2'(op), 3'd0, 3'd0, 3'd7, 0, 3'd0, 16'h0, "zero_ops");
    run_cmd(2'd0, 3'd1, 3'd2, 3'd0, 0, 3'd0, 16'h0, "rd_r0");
    do_load(3'd0, 16'hbeef);
    run_cmd(2'd0, 3'd1, 3'd2, 3'd3, 3, 3'd3, 16'h1234, "wb_collide");
    run_cmd(2'd0, 3'd1, 3'd2, 3'd7, 3, 3'd6, 16'habcd, "wb_diff");
    run_cmd(2'd1, 3'd4, 3'd5, 3'd7, 1, 3'd4, 16'h0000, "acc_load");
    run_cmd(2'd0, 3'd1, 3'd6, 3'd2, 2, 3'd1, 16'h0f0f, "exec_load");

    // handshake: cmd_valid held high with changing fields
    prev_valid = 1'b0;
    hold_rd = 3'd0;
    e = '0;
    cmd_valid = 1'b1;
    cmd_op = 2'($urandom); cmd_rs = 3'($urandom); cmd_rt = 3'($urandom); cmd_rd = 3'($urandom);
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) begin
        exp_q.push_back(ref_alu(cmd_op, m_regs[cmd_rs], m_regs[cmd_rt]));
        hold_rd = cmd_rd;
      end
      step();
      chk("hs_ready", cmd_ready, (k % 3 == 2));
      chk("hs_valid", rsp_valid, (k % 3 == 1));
      chk("hs_no_b2b", prev_valid & rsp_valid, 0);
      prev_valid = rsp_valid;
      if (k % 3 == 1) begin
        e = exp_q.pop_front();
        chk("hs_data", rsp_data, e[15:0]);
        chk("hs_cout", rsp_cout, e[16]);
      end
      if (k % 3 == 2) begin
        if (hold_rd != 3'd0) m_regs[hold_rd] = e[15:0];
        dbg_addr = hold_rd;
        #1 chk("hs_dbg", dbg_data, m_regs[hold_rd]);
      end
      cmd_op = 2'($urandom); cmd_rs = 3'($urandom); cmd_rt = 3'($urandom); cmd_rd = 3'($urandom);
    end
    cmd_valid = 1'b0;
    step();

    // randomized commands and loads
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) do_load(3'($urandom_range(0, 7)), 16'($urandom));
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), $urandom_range(0, 3), 3'($urandom_range(0, 7)),
              16'($urandom), "rand");
    end
    dump_check("rand_regs");

    // reset during EXEC aborts the command
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_rd = 3'd3;
    step();
    cmd_valid = 1'b0;
    chk("mid_exec_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_hold_valid", rsp_valid, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    exp_q.delete();
    chk("mid_rel_ready", cmd_ready, 1);
    chk("mid_rel_data", rsp_data, 16'h0000);
    chk("mid_rel_cout", rsp_cout, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_pulse", rsp_valid, 0);
    end
    dump_check("mid_regs");
    do_load(3'd1, 16'h0001);
    do_load(3'd2, 16'hffff);
    run_cmd(2'd0, 3'd1, 3'd2, 3'd3, 0, 3'd0, 16'h0, "post_rst_add");
    chk("post_rst_const", m_regs[3], 16'h0000);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
